// File: rtl/ls161_seq_ctrl.sv
// Sequencing controller for a 74LS161-style counter: drives Ld/D/CTT/CTP to form a
// preset-to-terminal modulo counter, counts completed periods and checks Q feedback.
module ls161_seq_ctrl (
    input  logic       CP,
    input  logic       CR,
    input  logic       start,
    input  logic       stop,
    input  logic       load_req,
    input  logic [3:0] preset,
    input  logic [3:0] term,
    input  logic [7:0] target_wraps,
    input  logic [3:0] Q_in,
    output logic       Ld,
    output logic [3:0] D,
    output logic       CTT,
    output logic       CTP,
    output logic [7:0] wrap_cnt,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WRAP_W = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  s_q, s_d;
    logic [CNT_W-1:0]  preset_q, preset_d;
    logic [CNT_W-1:0]  term_q, term_d;
    logic [WRAP_W-1:0] target_q, target_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic              err_q, err_d;
    logic              ld_q, ld_d;
    logic              ctt_q, ctt_d;
    logic              ctp_q, ctp_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              at_term;
    logic              latch_cfg;
    logic              clear_run;

    // Next-state, shadow count and registered-output computation.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        preset_d  = preset_q;
        term_d    = term_q;
        target_d  = target_q;
        wrap_d    = wrap_q;
        err_d     = err_q;
        latch_cfg = 1'b0;
        clear_run = 1'b0;
        at_term   = (s_q == term_q);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    latch_cfg = 1'b1;
                    clear_run = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
                s_d     = preset_q;
            end
            ST_RUN: begin
                // Shadow follows the counter on every RUN edge, whatever the next state.
                if (at_term) begin
                    s_d    = preset_q;
                    wrap_d = wrap_q + WRAP_W'(1);
                end else begin
                    s_d = s_q + CNT_W'(1);
                end
                if (stop) begin
                    state_d = ST_PAUSE;
                end else if (load_req) begin
                    state_d   = ST_LOAD;
                    latch_cfg = 1'b1;
                end else if (at_term && (target_q != '0) && (wrap_d == target_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_PAUSE;
                end else if (load_req) begin
                    state_d   = ST_LOAD;
                    latch_cfg = 1'b1;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    latch_cfg = 1'b1;
                    clear_run = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (latch_cfg) begin
            preset_d = preset;
            term_d   = term;
            target_d = target_wraps;
        end
        if (clear_run) begin
            wrap_d = '0;
            err_d  = 1'b0;
        end
        if (((state_q == ST_RUN) || (state_q == ST_PAUSE)) && (Q_in != s_q)) begin
            err_d = 1'b1;
        end

        // Outputs are derived from the post-edge state so they can be registered.
        ld_d   = ~((state_d == ST_LOAD) || ((state_d == ST_RUN) && (s_d == term_d)));
        ctt_d  = (state_d == ST_RUN) || (state_d == ST_PAUSE);
        ctp_d  = (state_d == ST_RUN);
        busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_PAUSE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            state_q  <= ST_IDLE;
            s_q      <= '0;
            preset_q <= '0;
            term_q   <= '0;
            target_q <= '0;
            wrap_q   <= '0;
            err_q    <= 1'b0;
            ld_q     <= 1'b1;
            ctt_q    <= 1'b0;
            ctp_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            preset_q <= preset_d;
            term_q   <= term_d;
            target_q <= target_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
            ld_q     <= ld_d;
            ctt_q    <= ctt_d;
            ctp_q    <= ctp_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Ld       = ld_q;
    assign D        = preset_q;
    assign CTT      = ctt_q;
    assign CTP      = ctp_q;
    assign wrap_cnt = wrap_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ls161_seq_ctrl.sv
// Scoreboard bench for ls161_seq_ctrl: a period-position reference model pushes
// expected outputs, a monitor pops and compares them, with a 74LS161 model in the loop.
module tb_ls161_seq_ctrl;

    logic       CP = 1'b0;
    logic       CR;
    logic       start, stop, load_req;
    logic [3:0] preset, term;
    logic [7:0] target_wraps;
    logic [3:0] Q_in;
    logic       Ld;
    logic [3:0] D;
    logic       CTT, CTP;
    logic [7:0] wrap_cnt;
    logic       busy, done, err;

    logic       q_force;
    logic [3:0] q_force_val;
    logic [3:0] cnt_q;

    typedef struct packed {
        logic       ld;
        logic [3:0] d;
        logic       ctt;
        logic       ctp;
        logic [7:0] wrap;
        logic       busy;
        logic       done;
        logic       err;
    } obs_t;

    localparam obs_t RST_OBS = '{1'b1, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};

    typedef enum int {M_IDLE, M_LOAD, M_RUN, M_PAUSE, M_DONE} mode_t;

    mode_t      m_mode;
    int         m_pos;
    int         m_wraps;
    logic [3:0] m_pre, m_term;
    logic [7:0] m_tgt;
    bit         m_err;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    ls161_seq_ctrl dut (
        .CP           (CP),
        .CR           (CR),
        .start        (start),
        .stop         (stop),
        .load_req     (load_req),
        .preset       (preset),
        .term         (term),
        .target_wraps (target_wraps),
        .Q_in         (Q_in),
        .Ld           (Ld),
        .D            (D),
        .CTT          (CTT),
        .CTP          (CTP),
        .wrap_cnt     (wrap_cnt),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 CP = ~CP;

    // Downstream 74LS161: clear, synchronous load, count when both enables are high.
    always @(posedge CP or negedge CR) begin
        if (!CR)              cnt_q <= 4'd0;
        else if (!Ld)         cnt_q <= D;
        else if (CTT && CTP)  cnt_q <= cnt_q + 4'd1;
    end

    assign Q_in = q_force ? q_force_val : cnt_q;

    // Reference model: the shadow is the position within the current period.
    function automatic int plen();
        return ((int'(m_term) - int'(m_pre)) & 15) + 1;
    endfunction

    function automatic logic [3:0] m_s();
        return 4'((int'(m_pre) + m_pos) & 15);
    endfunction

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_pos   = 0;
        m_wraps = 0;
        m_pre   = 4'd0;
        m_term  = 4'd0;
        m_tgt   = 8'd0;
        m_err   = 1'b0;
    endtask

    task automatic model_latch();
        m_pre  = preset;
        m_term = term;
        m_tgt  = target_wraps;
    endtask

    task automatic model_step(input logic [3:0] q, input logic st, input logic sp, input logic lr);
        bit chk;
        bit wrapped;
        chk     = ((m_mode == M_RUN) || (m_mode == M_PAUSE)) && (q != m_s());
        wrapped = 1'b0;
        case (m_mode)
            M_IDLE, M_DONE: begin
                if (st) begin
                    m_mode  = M_LOAD;
                    model_latch();
                    m_wraps = 0;
                    m_err   = 1'b0;
                end
            end
            M_LOAD: begin
                m_mode = M_RUN;
                m_pos  = 0;
            end
            M_RUN: begin
                wrapped = (m_pos == plen() - 1);
                if (wrapped) begin
                    m_pos   = 0;
                    m_wraps = (m_wraps + 1) % 256;
                end else begin
                    m_pos = m_pos + 1;
                end
                if (sp) m_mode = M_PAUSE;
                else if (lr) begin
                    m_mode = M_LOAD;
                    model_latch();
                end else if (wrapped && (m_tgt != 8'd0) && (m_wraps == int'(m_tgt)))
                    m_mode = M_DONE;
            end
            M_PAUSE: begin
                if (sp) m_mode = M_PAUSE;
                else if (lr) begin
                    m_mode = M_LOAD;
                    model_latch();
                end else if (st) m_mode = M_RUN;
            end
            default: m_mode = M_IDLE;
        endcase
        if (chk) m_err = 1'b1;
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.ld   = !((m_mode == M_LOAD) || ((m_mode == M_RUN) && (m_pos == plen() - 1)));
        o.d    = m_pre;
        o.ctt  = (m_mode == M_RUN) || (m_mode == M_PAUSE);
        o.ctp  = (m_mode == M_RUN);
        o.wrap = 8'(m_wraps);
        o.busy = (m_mode == M_LOAD) || (m_mode == M_RUN) || (m_mode == M_PAUSE);
        o.done = (m_mode == M_DONE);
        o.err  = m_err;
        return o;
    endfunction

    // One clock of stimulus: drive after the falling edge, predict the post-edge outputs.
    task automatic cyc(input logic st, input logic sp, input logic lr,
                       input logic frc = 1'b0, input logic [3:0] fv = 4'd0);
        logic [3:0] q_now;
        @(negedge CP);
        #1;
        start       = st;
        stop        = sp;
        load_req    = lr;
        q_force     = frc;
        q_force_val = fv;
        q_now       = frc ? fv : cnt_q;
        model_step(q_now, st, sp, lr);
        exp_q.push_back(model_obs());
    endtask

    task automatic do_reset();
        @(negedge CP);
        #1;
        CR       = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        load_req = 1'b0;
        q_force  = 1'b0;
        model_reset();
        repeat (2) @(negedge CP);
        #1;
        CR = 1'b1;
    endtask

    function automatic obs_t dut_obs();
        return {Ld, D, CTT, CTP, wrap_cnt, busy, done, err};
    endfunction

    initial begin : monitor
        obs_t e;
        obs_t g;
        int   n;
        n = 0;
        forever begin
            @(negedge CP or negedge CR);
            if (!CR) begin
                #1;
                g = dut_obs();
                checks++;
                if (g !== RST_OBS) begin
                    errors++;
                    $display("FAIL reset_values t=%0t got=%h want=%h", $time, g, RST_OBS);
                end
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = dut_obs();
                n++;
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL outputs n=%0d got ld=%b d=%h ctt=%b ctp=%b wrap=%0d busy=%b done=%b err=%b want ld=%b d=%h ctt=%b ctp=%b wrap=%0d busy=%b done=%b err=%b",
                             n, g.ld, g.d, g.ctt, g.ctp, g.wrap, g.busy, g.done, g.err,
                             e.ld, e.d, e.ctt, e.ctp, e.wrap, e.busy, e.done, e.err);
                end
            end
        end
    end

    initial begin : driver
        CR           = 1'b1;
        start        = 1'b0;
        stop         = 1'b0;
        load_req     = 1'b0;
        preset       = 4'd0;
        term         = 4'd0;
        target_wraps = 8'd0;
        q_force      = 1'b0;
        q_force_val  = 4'd0;
        model_reset();

        do_reset();
        repeat (3) cyc(1'b0, 1'b0, 1'b0);

        // Free-running 3..9 modulo run, then reset in the middle of it.
        preset = 4'd3; term = 4'd9; target_wraps = 8'd0;
        cyc(1'b1, 1'b0, 1'b0);
        repeat (30) cyc(1'b0, 1'b0, 1'b0);
        do_reset();
        repeat (2) cyc(1'b0, 1'b0, 1'b0);

        // 13..2 through 15->0, stopping after two periods; stop in DONE is ignored.
        preset = 4'd13; term = 4'd2; target_wraps = 8'd2;
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40 && m_mode != M_DONE; i++) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        // Restart from DONE, pause for four cycles, resume.
        preset = 4'd3; term = 4'd9; target_wraps = 8'd0;
        cyc(1'b1, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 1'b0);
        repeat (4) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (10) cyc(1'b0, 1'b0, 1'b0);

        // preset == term: a wrap every cycle, past 255 in free-run; stop beats load_req.
        do_reset();
        preset = 4'd5; term = 4'd5; target_wraps = 8'd0;
        cyc(1'b1, 1'b0, 1'b0);
        repeat (270) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);

        // Feedback error at S=4, kept through load_req, cleared by start from DONE.
        do_reset();
        preset = 4'd0; term = 4'd9; target_wraps = 8'd1;
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !(m_mode == M_RUN && m_s() == 4'd4); i++) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 30 && m_mode != M_DONE; i++) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);

        // Random traffic; configuration only changes while no run is latched.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic       st, sp, lr, fr;
            logic [3:0] fv;
            bool_idle: begin end
            if (m_mode == M_IDLE || m_mode == M_DONE) begin
                preset       = 4'($urandom_range(0, 15));
                term         = 4'($urandom_range(0, 15));
                target_wraps = 8'($urandom_range(0, 3));
            end
            st = ($urandom_range(0, 3) == 0);
            sp = ($urandom_range(0, 7) == 0);
            lr = ($urandom_range(0, 9) == 0);
            fr = ($urandom_range(0, 29) == 0);
            fv = 4'($urandom_range(0, 15));
            if (st && (m_mode == M_IDLE || m_mode == M_DONE)) sp = 1'b0;
            cyc(st, sp, lr, fr, fv);
        end

        @(negedge CP);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
